// File: rtl/mul_rot_unit_if.sv
// Request/response bundle between issue, the rotating multiplier and writeback.
interface mul_rot_unit_if #(
   parameter int XLEN = 32
);
   logic            in_valid_i;
   logic            in_ready_o;
   logic [1:0]      op_i;
   logic [XLEN-1:0] op_a_i;
   logic [XLEN-1:0] op_b_i;
   logic            flush_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [XLEN-1:0] result_o;
   logic            busy_o;

   modport slave (
      input  in_valid_i, op_i, op_a_i, op_b_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, busy_o
   );

   modport master (
      output in_valid_i, op_i, op_a_i, op_b_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, busy_o
   );
endinterface

// File: rtl/mul_rot_unit.sv
// Iterative RV32M multiplier: fixed A chunks times a rotating B register,
// one registered partial-product stage feeding a 2*XLEN accumulator.
module mul_rot_unit #(
   parameter int XLEN  = 32,
   parameter int CHUNK = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mul_rot_unit_if.slave bus
);
   localparam int LANES = XLEN / CHUNK;
   localparam int KW    = $clog2(LANES);
   localparam int AW    = 2 * XLEN;
   localparam int PW    = 2 * CHUNK + 2;
   localparam int SW    = $clog2(AW) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_t;

   state_t          state_reg, state_next;
   logic [KW-1:0]   k_reg;
   logic [XLEN-1:0] a_reg;
   logic [XLEN-1:0] b_rot_reg;
   logic [1:0]      op_reg;
   logic            sign_a_reg;
   logic            sign_b_reg;
   logic            pipe_valid_reg;
   logic [AW-1:0]   pipe_reg [LANES];
   logic [AW-1:0]   lane_prod [LANES];
   logic [AW-1:0]   pipe_sum;
   logic [AW-1:0]   acc_reg;
   logic            accept;
   logic            calc_step;
   logic            last_step;

   assign accept    = (state_reg == IDLE) && bus.in_valid_i && !bus.flush_i;
   assign calc_step = (state_reg == CALC) && !bus.flush_i;
   assign last_step = (k_reg == KW'(LANES - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid_i) begin
               if ((bus.op_a_i == '0) || (bus.op_b_i == '0))
                  state_next = DONE;
               else
                  state_next = CALC;
            end
         end
         CALC:    if (last_step) state_next = DRAIN;
         DRAIN:   state_next = DONE;
         DONE:    if (bus.out_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.flush_i)
         state_next = IDLE;
   end

   // B rotates toward lane 0, so lane i always holds original chunk (i+k) mod LANES.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic TOP_A = (gi == LANES - 1);
      logic [KW:0]          j_raw;
      logic [KW-1:0]        j_idx;
      logic [CHUNK-1:0]     a_chunk;
      logic [CHUNK-1:0]     b_chunk;
      logic signed [CHUNK:0] a_ext;
      logic signed [CHUNK:0] b_ext;
      logic signed [PW-1:0]  prod;
      logic [SW-1:0]         sh;

      assign j_raw   = (KW+1)'(gi) + {1'b0, k_reg};
      assign j_idx   = (j_raw >= (KW+1)'(LANES)) ? KW'(j_raw - (KW+1)'(LANES)) : KW'(j_raw);
      assign a_chunk = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunk = b_rot_reg[gi*CHUNK +: CHUNK];
      assign a_ext   = $signed({TOP_A & sign_a_reg & a_chunk[CHUNK-1], a_chunk});
      assign b_ext   = $signed({(j_idx == KW'(LANES - 1)) & sign_b_reg & b_chunk[CHUNK-1], b_chunk});
      assign prod    = PW'(a_ext) * PW'(b_ext);
      assign sh      = SW'(CHUNK) * (SW'(gi) + SW'(j_idx));
      assign lane_prod[gi] = AW'(prod) << sh;
   end

   always_comb begin
      pipe_sum = '0;
      for (int i = 0; i < LANES; i++)
         pipe_sum = pipe_sum + pipe_reg[i];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= IDLE;
         k_reg          <= '0;
         a_reg          <= '0;
         b_rot_reg      <= '0;
         op_reg         <= '0;
         sign_a_reg     <= 1'b0;
         sign_b_reg     <= 1'b0;
         pipe_valid_reg <= 1'b0;
         acc_reg        <= '0;
         for (int i = 0; i < LANES; i++)
            pipe_reg[i] <= '0;
      end else begin
         state_reg      <= state_next;
         pipe_valid_reg <= calc_step;
         if (calc_step) begin
            for (int i = 0; i < LANES; i++)
               pipe_reg[i] <= lane_prod[i];
            b_rot_reg <= {b_rot_reg[CHUNK-1:0], b_rot_reg[XLEN-1:CHUNK]};
            k_reg     <= last_step ? '0 : k_reg + KW'(1);
         end
         if (accept) begin
            a_reg      <= bus.op_a_i;
            b_rot_reg  <= bus.op_b_i;
            op_reg     <= bus.op_i;
            sign_a_reg <= bus.op_i[0] ^ bus.op_i[1];
            sign_b_reg <= (bus.op_i == 2'b01);
            acc_reg    <= '0;
            k_reg      <= '0;
         end else if (pipe_valid_reg) begin
            acc_reg <= acc_reg + pipe_sum;
         end
      end
   end

   assign bus.in_ready_o  = (state_reg == IDLE);
   assign bus.busy_o      = (state_reg != IDLE);
   assign bus.out_valid_o = (state_reg == DONE);
   assign bus.result_o    = (op_reg == 2'b00) ? acc_reg[XLEN-1:0] : acc_reg[AW-1:XLEN];
endmodule
